io_bank_cfg: RTL and testbench

Parametrised multi-channel embedded I/O bank tile: successor to the single-pad logical IO tile. It drives `NUM_IO` SoC pad channels and owns a per-channel direction and polarity configuration. Configuration is loaded through a counted, shadowed configuration-chain segment with an explicit commit handshake. It sits on the FPGA fabric perimeter between the routing grid and the SoC GPIO pads, and forms one segment of the global `ccff` configuration chain.

---
 rtl/io_bank_pkg.sv | 20 ++
 rtl/io_bank_cfg_chain.sv | 112 +++++++++++
 rtl/io_bank_cfg.sv | 60 ++++++
 tb/tb_io_bank_cfg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared constants, FSM encoding and counter sizing for the io_bank configuration tile.
// No timing of its own: this package holds declarations only.
package io_bank_pkg;

   localparam int CFG_BITS_PER_IO = 2;
   localparam int CFG_OE          = 0;
   localparam int CFG_INV         = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ACTIVE = 2'd2
   } cfg_state_e;

   // Counter must reach CHAIN_LEN+1 so an overshift stays distinguishable from a full load.
   function automatic int cnt_width(input int chain_len);
      return $clog2(chain_len + 2);
   endfunction

endpackage

// File: rtl/io_bank_cfg_chain.sv
// Shadowed config chain segment: shift register, saturating bit counter, commit/capture control, FSM.
// Tail is registered (one bit per shift); commit is seen on the edge that samples load; readback via IO_BANK_READBACK_EN.
module io_bank_cfg_chain
   import io_bank_pkg::*;
#(
   parameter int CHAIN_LEN = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_head,
   input  logic                 i_en,
   input  logic                 i_load,
`ifdef IO_BANK_READBACK_EN
   input  logic                 i_capture,
`endif
   output logic [CHAIN_LEN-1:0] o_active,
   output logic                 o_cfg_ready,
   output logic                 o_cfg_err,
   output logic                 o_tail
);

   localparam int              CW       = cnt_width(CHAIN_LEN);
   localparam logic [CW-1:0]   CNT_FULL = CW'(CHAIN_LEN);
   localparam logic [CW-1:0]   CNT_SAT  = CW'(CHAIN_LEN + 1);

   cfg_state_e             r_state, w_state_nxt;
   logic [CHAIN_LEN-1:0]   r_sr, w_sr_nxt;
   logic [CHAIN_LEN-1:0]   r_active, w_active_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_ready, w_ready_nxt;
   logic                   r_err, w_err_nxt;

   logic w_cap;
   logic w_do_shift;
   logic w_do_commit;
   logic w_do_capture;
   logic w_accept;
   logic w_cnt_clr;
   logic w_conflict;

`ifdef IO_BANK_READBACK_EN
   assign w_cap = i_capture;
`else
   assign w_cap = 1'b0;
`endif

   assign w_do_shift   = i_en & ~i_load & ~w_cap;
   assign w_do_commit  = i_load & ~i_en & ~w_cap;
   assign w_do_capture = w_cap & ~i_en & ~i_load;
   assign w_accept     = w_do_commit & (r_cnt == CNT_FULL);
   // Any overlapping control request is rejected as a whole; only en+load still restarts the count.
   assign w_conflict   = (i_en & i_load) | (w_cap & (i_en | i_load));
   assign w_cnt_clr    = w_do_commit | w_do_capture | (i_en & i_load & ~w_cap);

   always_comb begin
      w_sr_nxt     = r_sr;
      w_cnt_nxt    = r_cnt;
      w_active_nxt = r_active;
      w_ready_nxt  = r_ready;
      w_err_nxt    = r_err;
      w_state_nxt  = r_state;

      if (w_do_shift) begin
         w_sr_nxt  = {r_sr[CHAIN_LEN-2:0], i_head};
         w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
      end
      if (w_do_capture) begin
         w_sr_nxt = r_active;
      end
      if (w_cnt_clr) begin
         w_cnt_nxt = '0;
      end

      if (w_accept) begin
         w_active_nxt = r_sr;
         w_ready_nxt  = 1'b1;
         w_err_nxt    = 1'b0;
      end else if (w_do_commit || w_conflict) begin
         w_err_nxt = 1'b1;
      end

      if (w_do_shift) begin
         w_state_nxt = SHIFT;
      end else if (w_cnt_clr) begin
         w_state_nxt = w_ready_nxt ? ACTIVE : IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_sr     <= '0;
         r_cnt    <= '0;
         r_active <= '0;
         r_ready  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sr     <= w_sr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_active <= w_active_nxt;
         r_ready  <= w_ready_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign o_active    = r_active;
   assign o_cfg_ready = r_ready;
   assign o_cfg_err   = r_err;
   assign o_tail      = r_sr[CHAIN_LEN-1];

endmodule

// File: rtl/io_bank_cfg.sv
// Multi-channel embedded I/O bank tile: per-channel direction/polarity from a shadowed ccff segment (IO_BANK_READBACK_EN adds capture).
// Pad/fabric paths are purely combinational; isolation gates with zero latency; no backpressure.
module io_bank_cfg
   import io_bank_pkg::*;
#(
   parameter int NUM_IO = 4
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              IO_ISOL_N,
   input  logic              ccff_head,
   input  logic              ccff_en,
   input  logic              ccff_load,
`ifdef IO_BANK_READBACK_EN
   input  logic              ccff_capture,
`endif
   output logic              ccff_tail,
   output logic              cfg_ready,
   output logic              cfg_err,
   input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
   input  logic [NUM_IO-1:0] io_outpad,
   output logic [NUM_IO-1:0] io_inpad
);

   localparam int CHAIN_LEN = CFG_BITS_PER_IO * NUM_IO;

   logic [CHAIN_LEN-1:0] w_active;
   logic                 w_safe;

   io_bank_cfg_chain #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
      .i_clk       (prog_clk),
      .i_rst_n     (prog_reset_n),
      .i_head      (ccff_head),
      .i_en        (ccff_en),
      .i_load      (ccff_load),
`ifdef IO_BANK_READBACK_EN
      .i_capture   (ccff_capture),
`endif
      .o_active    (w_active),
      .o_cfg_ready (cfg_ready),
      .o_cfg_err   (cfg_err),
      .o_tail      (ccff_tail)
   );

   assign w_safe = IO_ISOL_N & cfg_ready;

   for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_ch
      logic w_oe;
      logic w_inv;
      assign w_oe  = w_active[CFG_BITS_PER_IO*gi + CFG_OE];
      assign w_inv = w_active[CFG_BITS_PER_IO*gi + CFG_INV];

      assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[gi] = ~(w_safe & w_oe);
      assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[gi] = w_safe & w_oe & (io_outpad[gi] ^ w_inv);
      assign io_inpad[gi] = w_safe & ~w_oe & (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[gi] ^ w_inv);
   end

endmodule

// File: tb/tb_io_bank_cfg.sv
// Directed bench for io_bank_cfg (NUM_IO=4): reset, commit accept/reject, conflicts, isolation, readback, async reset.
module tb_io_bank_cfg;

   logic       prog_clk;
   logic       prog_reset_n;
   logic       IO_ISOL_N;
   logic       ccff_head;
   logic       ccff_en;
   logic       ccff_load;
`ifdef IO_BANK_READBACK_EN
   logic       ccff_capture;
`endif
   logic       ccff_tail;
   logic       cfg_ready;
   logic       cfg_err;
   logic [3:0] pad_in;
   logic [3:0] pad_out;
   logic [3:0] pad_dir;
   logic [3:0] io_outpad;
   logic [3:0] io_inpad;

   int n_checks = 0;
   int n_errors = 0;

   io_bank_cfg #(.NUM_IO(4)) dut (
      .prog_clk                         (prog_clk),
      .prog_reset_n                     (prog_reset_n),
      .IO_ISOL_N                        (IO_ISOL_N),
      .ccff_head                        (ccff_head),
      .ccff_en                          (ccff_en),
      .ccff_load                        (ccff_load),
`ifdef IO_BANK_READBACK_EN
      .ccff_capture                     (ccff_capture),
`endif
      .ccff_tail                        (ccff_tail),
      .cfg_ready                        (cfg_ready),
      .cfg_err                          (cfg_err),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
      .io_outpad                        (io_outpad),
      .io_inpad                         (io_inpad)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic shift_bits(input logic [15:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ccff_en   = 1'b1;
         ccff_head = d[i];
         step();
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic commit();
      ccff_load = 1'b1;
      step();
      ccff_load = 1'b0;
   endtask

   task automatic chk_pads(input string tag, input logic [3:0] dir, input logic [3:0] out,
                           input logic [3:0] inp);
      #1;
      chk({tag, ".dir"}, 32'(pad_dir), 32'(dir));
      chk({tag, ".out"}, 32'(pad_out), 32'(out));
      chk({tag, ".inpad"}, 32'(io_inpad), 32'(inp));
   endtask

   initial begin
      logic [7:0] rb;
      prog_reset_n = 1'b0;
      IO_ISOL_N    = 1'b1;
      ccff_head    = 1'b0;
      ccff_en      = 1'b0;
      ccff_load    = 1'b0;
`ifdef IO_BANK_READBACK_EN
      ccff_capture = 1'b0;
`endif
      io_outpad    = 4'b1111;
      pad_in       = 4'b1111;
      #12;
      chk_pads("reset", 4'b1111, 4'b0000, 4'b0000);
      chk("reset.ready", 32'(cfg_ready), 32'd0);
      chk("reset.err", 32'(cfg_err), 32'd0);
      chk("reset.tail", 32'(ccff_tail), 32'd0);
      prog_reset_n = 1'b1;
      step();

      // Load with nothing shifted in: rejected while idle
      commit();
      chk("empty_load.err", 32'(cfg_err), 32'd1);
      chk("empty_load.ready", 32'(cfg_ready), 32'd0);
      chk_pads("empty_load", 4'b1111, 4'b0000, 4'b0000);

      // First valid configuration 8'hA5
      shift_bits(16'h00A5, 8);
      chk("a5.tail_latency", 32'(ccff_tail), 32'd1);
      chk_pads("a5.preload", 4'b1111, 4'b0000, 4'b0000);
      commit();
      chk("a5.ready", 32'(cfg_ready), 32'd1);
      chk("a5.err", 32'(cfg_err), 32'd0);
      io_outpad = 4'b0011; pad_in = 4'b0000;
      chk_pads("a5.p1", 4'b1100, 4'b0011, 4'b1100);
      io_outpad = 4'b1110; pad_in = 4'b0111;
      chk_pads("a5.p2", 4'b1100, 4'b0010, 4'b1000);

      // Short load (7 bits): old config keeps driving, including mid-shift
      shift_bits(16'h0055, 4);
      chk_pads("mid_shift", 4'b1100, 4'b0010, 4'b1000);
      shift_bits(16'h0005, 3);
      commit();
      chk("short.err", 32'(cfg_err), 32'd1);
      chk("short.ready", 32'(cfg_ready), 32'd1);
      chk_pads("short", 4'b1100, 4'b0010, 4'b1000);

      // Overshift (9 bits) also rejected
      shift_bits(16'h015A, 9);
      commit();
      chk("long.err", 32'(cfg_err), 32'd1);
      chk_pads("long", 4'b1100, 4'b0010, 4'b1000);

      // Correct load of 8'h5A clears the error: ch0/1 input inverted, ch2/3 output
      shift_bits(16'h005A, 8);
      commit();
      chk("5a.err", 32'(cfg_err), 32'd0);
      io_outpad = 4'b0101; pad_in = 4'b0000;
      chk_pads("5a", 4'b0011, 4'b0100, 4'b0011);

      // en+load together: no shift (tail stays at sr MSB 0), error, counter restarts
      ccff_en = 1'b1; ccff_load = 1'b1; ccff_head = 1'b1;
      step();
      ccff_en = 1'b0; ccff_load = 1'b0; ccff_head = 1'b0;
      chk("conflict.err", 32'(cfg_err), 32'd1);
      chk("conflict.tail", 32'(ccff_tail), 32'd0);
      chk_pads("conflict", 4'b0011, 4'b0100, 4'b0011);
      shift_bits(16'h00A5, 8);
      commit();
      chk("after_conflict.err", 32'(cfg_err), 32'd0);
      io_outpad = 4'b0011; pad_in = 4'b0000;
      chk_pads("after_conflict", 4'b1100, 4'b0011, 4'b1100);

      // Isolation is combinational in both directions
      IO_ISOL_N = 1'b0;
      chk_pads("isol", 4'b1111, 4'b0000, 4'b0000);
      chk("isol.ready", 32'(cfg_ready), 32'd1);
      IO_ISOL_N = 1'b1;
      chk_pads("unisol", 4'b1100, 4'b0011, 4'b1100);

`ifdef IO_BANK_READBACK_EN
      ccff_capture = 1'b1;
      step();
      ccff_capture = 1'b0;
      rb = 8'b1010_0101;
      for (int i = 7; i >= 0; i--) begin
         chk($sformatf("readback.bit%0d", i), 32'(ccff_tail), 32'(rb[i]));
         ccff_en = 1'b1;
         step();
         ccff_en = 1'b0;
      end
      ccff_capture = 1'b1; ccff_load = 1'b1;
      step();
      ccff_capture = 1'b0; ccff_load = 1'b0;
      chk("cap_conflict.err", 32'(cfg_err), 32'd1);
      chk_pads("cap_conflict", 4'b1100, 4'b0011, 4'b1100);
      ccff_capture = 1'b1;
      step();
      ccff_capture = 1'b0;
`else
      rb = 8'h00;
`endif

      // Asynchronous reset in the middle of a shift sequence
      shift_bits(16'h00FF, 3);
      #2;
      prog_reset_n = 1'b0;
      chk_pads("midreset", 4'b1111, 4'b0000, 4'b0000);
      chk("midreset.ready", 32'(cfg_ready), 32'd0);
      chk("midreset.err", 32'(cfg_err), 32'd0);
      chk("midreset.tail", 32'(ccff_tail), 32'd0);
      step();
      prog_reset_n = 1'b1;
      step();
      // Counter was cleared: 8 shifts commit cleanly after reset
      shift_bits(16'h00A5, 8);
      commit();
      chk("post_reset.ready", 32'(cfg_ready), 32'(rb[0] | 1'b1));
      chk("post_reset.err", 32'(cfg_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
